// File: rtl/sw_operand_loader_pkg.sv
// Shared definitions for the switch/button operand loader: load-phase
// encodings, phase-0 config word field positions, debounce default.
package sw_operand_loader_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    P_CFG  = 2'd0,
    P_DATA = 2'd1,
    P_PC   = 2'd2
  } phase_t;

  // Phase-0 config word layout (MSB/LSB of each field)
  localparam int unsigned CFG_RA_MSB = 31;
  localparam int unsigned CFG_RA_LSB = 28;
  localparam int unsigned CFG_RB_MSB = 27;
  localparam int unsigned CFG_RB_LSB = 24;
  localparam int unsigned CFG_RC_MSB = 23;
  localparam int unsigned CFG_RC_LSB = 20;
  localparam int unsigned CFG_M_MSB  = 15;
  localparam int unsigned CFG_M_LSB  = 11;
  localparam int unsigned CFG_WA_MSB = 7;
  localparam int unsigned CFG_WA_LSB = 4;
  localparam int unsigned CFG_WR_BIT = 1;
  localparam int unsigned CFG_WP_BIT = 0;

endpackage

// File: rtl/sw_operand_loader_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce counter
// and a one-cycle pulse in the cycle the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then accept a new level only after it differed for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/sw_operand_loader.sv
// Operand loader: sequences config / write-data / new-PC captures from one
// 32-bit switch bank and emits a single-cycle commit strobe.
// Optional feature macro: LOADER_UNDO_EN (btn_back steps the phase back).
module sw_operand_loader
  import sw_operand_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] sw,
  input  logic        btn_arm,
  input  logic        btn_load,
  input  logic        btn_commit,
  input  logic        btn_back,
  output logic [3:0]  r_addr_a,
  output logic [3:0]  r_addr_b,
  output logic [3:0]  r_addr_c,
  output logic [4:0]  m,
  output logic [3:0]  w_addr,
  output logic        write_reg,
  output logic        write_pc,
  output logic [31:0] w_data,
  output logic [31:0] pc_new,
  output logic [1:0]  phase,
  output logic [2:0]  loaded,
  output logic        commit_pulse,
  output logic        err
);

  logic w_arm, w_arm_rise_nc;
  logic w_load_lvl_nc, w_load_edge;
  logic w_commit_lvl_nc, w_commit_edge;
  logic w_back_edge;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_arm (
    .i_clk(clk), .i_rst(Rst), .i_raw(btn_arm), .o_level(w_arm), .o_rise(w_arm_rise_nc));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load (
    .i_clk(clk), .i_rst(Rst), .i_raw(btn_load), .o_level(w_load_lvl_nc), .o_rise(w_load_edge));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_commit (
    .i_clk(clk), .i_rst(Rst), .i_raw(btn_commit), .o_level(w_commit_lvl_nc), .o_rise(w_commit_edge));

`ifdef LOADER_UNDO_EN
  logic w_back_lvl_nc;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_back (
    .i_clk(clk), .i_rst(Rst), .i_raw(btn_back), .o_level(w_back_lvl_nc), .o_rise(w_back_edge));
  logic w_unused;
  assign w_unused = w_arm_rise_nc | w_load_lvl_nc | w_commit_lvl_nc | w_back_lvl_nc;
`else
  assign w_back_edge = 1'b0;
  logic w_unused;
  assign w_unused = w_arm_rise_nc | w_load_lvl_nc | w_commit_lvl_nc | btn_back | w_back_edge;
`endif

  phase_t     r_phase, w_phase_n;
  logic [2:0] r_loaded, w_loaded_n;
  logic       r_pulse, w_pulse_n;
  logic       r_err, w_err_n;
  logic       w_cap_cfg, w_cap_data, w_cap_pc;

  // Phase/mask/strobe/error state register
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_phase  <= P_CFG;
      r_loaded <= '0;
      r_pulse  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_phase  <= w_phase_n;
      r_loaded <= w_loaded_n;
      r_pulse  <= w_pulse_n;
      r_err    <= w_err_n;
    end
  end

  // Next state: commit is resolved on the pre-load mask, then a load (or
  // back step) is applied to the post-commit phase.
  always_comb begin
    w_phase_n  = r_phase;
    w_loaded_n = r_loaded;
    w_pulse_n  = 1'b0;
    w_err_n    = r_err;
    w_cap_cfg  = 1'b0;
    w_cap_data = 1'b0;
    w_cap_pc   = 1'b0;
    if (w_commit_edge) begin
      if (r_loaded == 3'b111) begin
        w_pulse_n  = 1'b1;
        w_loaded_n = '0;
        w_phase_n  = P_CFG;
        w_err_n    = 1'b0;
      end else begin
        w_err_n = 1'b1;
      end
    end
    if (w_load_edge && w_arm) begin
      case (w_phase_n)
        P_CFG:   begin w_cap_cfg  = 1'b1; w_loaded_n[0] = 1'b1; w_phase_n = P_DATA; end
        P_DATA:  begin w_cap_data = 1'b1; w_loaded_n[1] = 1'b1; w_phase_n = P_PC;   end
        P_PC:    begin w_cap_pc   = 1'b1; w_loaded_n[2] = 1'b1; w_phase_n = P_CFG;  end
        default: ;
      endcase
    end else if (w_back_edge && w_arm) begin
      case (w_phase_n)
        P_CFG:   begin w_phase_n = P_PC;   w_loaded_n[2] = 1'b0; end
        P_DATA:  begin w_phase_n = P_CFG;  w_loaded_n[0] = 1'b0; end
        P_PC:    begin w_phase_n = P_DATA; w_loaded_n[1] = 1'b0; end
        default: ;
      endcase
    end
  end

  // Operand field registers, captured per phase
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_c  <= '0;
      m         <= '0;
      w_addr    <= '0;
      write_reg <= 1'b0;
      write_pc  <= 1'b0;
      w_data    <= '0;
      pc_new    <= '0;
    end else begin
      if (w_cap_cfg) begin
        r_addr_a  <= sw[CFG_RA_MSB:CFG_RA_LSB];
        r_addr_b  <= sw[CFG_RB_MSB:CFG_RB_LSB];
        r_addr_c  <= sw[CFG_RC_MSB:CFG_RC_LSB];
        m         <= sw[CFG_M_MSB:CFG_M_LSB];
        w_addr    <= sw[CFG_WA_MSB:CFG_WA_LSB];
        write_reg <= sw[CFG_WR_BIT];
        write_pc  <= sw[CFG_WP_BIT];
      end
      if (w_cap_data) w_data <= sw;
      if (w_cap_pc)   pc_new <= sw;
    end
  end

  assign phase        = r_phase;
  assign loaded       = r_loaded;
  assign commit_pulse = r_pulse;
  assign err          = r_err;

endmodule

// File: tb/tb_sw_operand_loader.sv
// Scoreboard bench for sw_operand_loader (DEBOUNCE_CYCLES=4).
module tb_sw_operand_loader;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] sw = '0;
  logic        btn_arm = 1'b0, btn_load = 1'b0, btn_commit = 1'b0, btn_back = 1'b0;
  logic [3:0]  r_addr_a, r_addr_b, r_addr_c, w_addr;
  logic [4:0]  m;
  logic        write_reg, write_pc, commit_pulse, err;
  logic [31:0] w_data, pc_new;
  logic [1:0]  phase;
  logic [2:0]  loaded;

  sw_operand_loader #(.DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
    .clk(clk), .Rst(Rst), .sw(sw), .btn_arm(btn_arm), .btn_load(btn_load),
    .btn_commit(btn_commit), .btn_back(btn_back),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_addr_c(r_addr_c), .m(m),
    .w_addr(w_addr), .write_reg(write_reg), .write_pc(write_pc),
    .w_data(w_data), .pc_new(pc_new), .phase(phase), .loaded(loaded),
    .commit_pulse(commit_pulse), .err(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pulse;
    logic [1:0]  phase;
    logic [2:0]  loaded;
    logic        err;
    logic [3:0]  ra, rb, rc;
    logic [4:0]  m;
    logic [3:0]  wa;
    logic        wr, wp;
    logic [31:0] wd, pc;
  } outs_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  outs_t exp_q[$];
  int    cyc_q[$];
  string nm_q[$];
  outs_t m_st = '0;
  logic  m_arm = 1'b0;
  outs_t prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outs_t gather();
    outs_t o;
    o = {commit_pulse, phase, loaded, err, r_addr_a, r_addr_b, r_addr_c, m,
         w_addr, write_reg, write_pc, w_data, pc_new};
    return o;
  endfunction

  // Monitor: any strobe or change of registered outputs is a DUT event
  always @(negedge clk) begin
    outs_t cur, cmp, e;
    int    c;
    string n;
    cur = gather();
    cmp = cur;
    cmp.pulse = 1'b0;
    if (Rst) begin
      prev = cmp;
    end else if (cur.pulse || cmp != prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        n = nm_q.pop_front();
        if (cur !== e || (c >= 0 && c != cyc))
        begin
          bad++;
          $display("FAIL %s got=%h at cyc %0d, want=%h at cyc %0d", n, cur, cyc, e, c);
        end
      end
      prev = cmp;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference behaviour; returns 1 when the transition is observable
  function automatic bit model(input bit ld, input bit cm, input bit bk, output outs_t n);
    outs_t a, b;
    n = m_st;
    n.pulse = 1'b0;
    if (cm) begin
      if (n.loaded == 3'b111) begin
        n.pulse = 1'b1; n.loaded = 3'b000; n.phase = 2'd0; n.err = 1'b0;
      end else n.err = 1'b1;
    end
    if (ld && m_arm) begin
      if (n.phase == 2'd0) begin
        n.ra = sw[31:28]; n.rb = sw[27:24]; n.rc = sw[23:20]; n.m = sw[15:11];
        n.wa = sw[7:4]; n.wr = sw[1]; n.wp = sw[0]; n.loaded[0] = 1'b1; n.phase = 2'd1;
      end else if (n.phase == 2'd1) begin
        n.wd = sw; n.loaded[1] = 1'b1; n.phase = 2'd2;
      end else begin
        n.pc = sw; n.loaded[2] = 1'b1; n.phase = 2'd0;
      end
    end
`ifdef LOADER_UNDO_EN
    else if (bk && m_arm) begin
      if (n.phase == 2'd0) begin n.phase = 2'd2; n.loaded[2] = 1'b0; end
      else if (n.phase == 2'd1) begin n.phase = 2'd0; n.loaded[0] = 1'b0; end
      else begin n.phase = 2'd1; n.loaded[1] = 1'b0; end
    end
`else
    if (bk) n.pulse = n.pulse;
`endif
    a = n; a.pulse = 1'b0;
    b = m_st; b.pulse = 1'b0;
    return n.pulse || (a != b);
  endfunction

  task automatic expect_at(input bit ld, input bit cm, input bit bk, input int at, input string nm);
    outs_t n;
    if (model(ld, cm, bk, n)) begin
      exp_q.push_back(n);
      cyc_q.push_back(at);
      nm_q.push_back(nm);
    end
    m_st = n;
    m_st.pulse = 1'b0;
  endtask

  // Clean press/release of the selected buttons with sw presented
  task automatic press(input bit ld, input bit cm, input bit bk, input logic [31:0] s, input string nm);
    sw = s;
    expect_at(ld, cm, bk, cyc + N + 3, nm);
    btn_load = ld; btn_commit = cm; btn_back = bk;
    cycles(N + 6);
    btn_load = 1'b0; btn_commit = 1'b0; btn_back = 1'b0;
    cycles(N + 6);
  endtask

  task automatic check_zero(input string nm);
    total++;
    if (gather() !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", nm, gather());
    end
  endtask

  task automatic arm(input logic v);
    btn_arm = v;
    cycles(N + 6);
    m_arm = v;
  endtask

  initial begin
    cycles(3);
    check_zero("reset_state");
    Rst = 1'b0;
    cycles(2);
    arm(1'b1);

    // Full three-phase load, then commit
    press(1, 0, 0, 32'h1230_F8A3, "load_cfg");
    press(1, 0, 0, 32'hDEAD_BEEF, "load_data");
    press(1, 0, 0, 32'h0000_0100, "load_pc");
    press(0, 1, 0, 32'h0000_0100, "commit_ok");

    // Early commit rejected, then completed
    press(1, 0, 0, 32'h4567_0012, "load_cfg2");
    press(1, 0, 0, 32'hCAFE_0001, "load_data2");
    press(0, 1, 0, 32'hCAFE_0001, "commit_reject");
    press(1, 0, 0, 32'h8000_0004, "load_pc2");
    press(0, 1, 0, 32'h8000_0004, "commit_after_err");

    // Disarmed load is ignored
    arm(1'b0);
    press(1, 0, 0, 32'hFFFF_FFFF, "load_disarmed");
    arm(1'b1);

    // Bounced load: 1-0-1 at 2-cycle spacing then held
    sw = 32'h9876_5432;
    btn_load = 1'b1; cycles(2);
    btn_load = 1'b0; cycles(2);
    expect_at(1, 0, 0, cyc + N + 3, "bounce_load");
    btn_load = 1'b1; cycles(N + 6);
    btn_load = 1'b0; cycles(N + 6);
    press(1, 0, 0, 32'h1111_2222, "load_data3");
    press(1, 0, 0, 32'h3333_4444, "load_pc3");

    // Simultaneous commit and load with full mask
    press(1, 1, 0, 32'hABC0_A856, "commit_and_load");

    // Async reset at phase 2, loaded 011, with commit mid-debounce
    press(1, 0, 0, 32'h5555_AAAA, "load_before_reset");
    btn_commit = 1'b1;
    cycles(3);
    #2 Rst = 1'b1;
    #1 check_zero("async_reset");
    btn_commit = 1'b0;
    m_st = '0; m_arm = 1'b0;
    cycles(2);
    Rst = 1'b0;
    cycles(N + 6);
    m_arm = 1'b1;
    cycles(N + 6);

`ifdef LOADER_UNDO_EN
    press(1, 0, 0, 32'h1230_F8A3, "undo_load_cfg");
    press(0, 0, 1, 32'h1230_F8A3, "undo_back");
    press(1, 0, 1, 32'h2340_0000, "load_beats_back");
`endif

    cycles(20);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d pending want=0 (first %s)", exp_q.size(), nm_q[0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_operand_loader.md
Name: sw_operand_loader

Overview:
- Upstream stage of the register-file test harness. Converts raw slide switches and mechanical push buttons into registered operand and control fields for the register file.
- Debounces the buttons and sequences a 3-phase load (config word, write data, new PC) from the one 32-bit switch bank.
- Issues a single-cycle commit strobe, in the system clock domain, that drives the register file's write enable.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required before a button edge is accepted (10 ms at 100 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- Rst  in  1  reset, asynchronous, active-high.
- sw  in  32  raw switch bank; bit 31 is the MSB.
- btn_arm  in  1  raw level. Loading is permitted only while the debounced level is 1.
- btn_load  in  1  raw button. A debounced rising edge captures sw into the current phase.
- btn_commit  in  1  raw button. A debounced rising edge requests a commit.
- btn_back  in  1  raw button. Steps the phase back; used only with the optional feature.
- r_addr_a, r_addr_b, r_addr_c  out  4 each  read addresses.
- m  out  5  processor mode field.
- w_addr  out  4  write address.
- write_reg, write_pc  out  1 each  write enables carried with the commit.
- w_data  out  32  register write data.
- pc_new  out  32  PC write data.
- phase  out  2  current load phase (0, 1 or 2).
- loaded  out  3  per-phase loaded mask.
- commit_pulse  out  1  one-cycle strobe.
- err  out  1  sticky flag: a commit was rejected.

Behaviour:
- Reset: every output register clears to 0 (fields, w_data, pc_new, phase, loaded, commit_pulse, err). Debounce counters and synchroniser flops also clear to 0.
- Synchronisation: every button passes through a 2-flop synchroniser.
- Debounce: the debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
- Edge detection: the edge pulse is 1 cycle wide and occurs in the cycle the debounced level rises.
- Latency: from a clean raw press, the edge pulse appears DEBOUNCE_CYCLES+3 cycles after the press.
- Phase FSM states:
  - P_CFG (0), P_DATA (1), P_PC (2).
  - Each state moves to the next on an accepted load; P_PC wraps to P_CFG.
- Accepted load: a load edge while the armed level is 1. A load edge while disarmed is ignored; no field changes.
- Phase-0 capture (P_CFG):
  - r_addr_a = sw[31:28], r_addr_b = sw[27:24], r_addr_c = sw[23:20].
  - m = sw[15:11], w_addr = sw[7:4].
  - write_reg = sw[1], write_pc = sw[0].
- Phase-1 capture (P_DATA): w_data = sw.
- Phase-2 capture (P_PC): pc_new = sw.
- loaded mask: an accepted load sets loaded[phase]. Reloading an already-loaded phase overwrites its fields; the mask bit stays set.
- Commit edge with loaded == 3'b111:
  - commit_pulse = 1 for exactly the next cycle.
  - loaded clears to 0 and phase returns to 0.
  - Fields hold their values.
- Commit edge with loaded != 3'b111: no pulse; err is set. err clears only on reset or on a later successful commit.
- Simultaneous load and commit edges in the same cycle: commit is evaluated first, on the pre-load mask. The load is then applied to the post-commit phase. So a successful commit followed by a load captures into P_CFG and sets loaded = 3'b001.
- Reset asserted mid-debounce or mid-pulse: everything clears immediately; no pulse is emitted after reset releases.

Optional Feature:
- Macro: LOADER_UNDO_EN.
- Defined: a debounced btn_back edge while armed decrements phase (0 wraps to 2) and clears loaded at the new phase. If a load edge occurs in the same cycle, the load wins and back is ignored.
- Not defined: btn_back is unused, no debouncer is instantiated for it, and behaviour is as above.

Decomposition:
- Shared package holds:
  - Phase encodings P_CFG/P_DATA/P_PC.
  - Field bit-position constants for the phase-0 word.
  - The DEBOUNCE_CYCLES default.
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse), instantiated once per button.

Test Plan (DEBOUNCE_CYCLES=4):
- Arm; load sw=32'h1230_F8A3, then 32'hDEAD_BEEF, then 32'h0000_0100 -> r_addr_a=1, r_addr_b=2, r_addr_c=3, m=5'h1F, w_addr=4'hA, write_reg=1, write_pc=1, w_data=DEADBEEF, pc_new=00000100, loaded=111, phase=0.
- After the full load, commit -> commit_pulse high for exactly 1 cycle, loaded=000, err=0.
- Commit after only two loads -> no pulse, err=1. Then a third load and a commit -> pulse, err=0.
- btn_load bounced 1-0-1 at 2-cycle spacing, then held -> exactly one capture, occurring DEBOUNCE_CYCLES+3 cycles after the final rise.
- Load and commit edges in the same cycle with loaded=111 -> pulse; loaded=001 with the new config captured.
- Rst asserted while phase=2, loaded=011 -> all outputs 0 asynchronously. With LOADER_UNDO_EN, back from phase 1 -> phase 0, loaded[0]=0.
